ping_tx_arbiter: RTL and testbench

PING_TX_ARBITER -- requirements
Module: ping_tx_arbiter

---
 rtl/opb_emu_pkg.sv | 37 +++
 rtl/ping_tx_arbiter_if.sv | 22 ++
 rtl/tick_edge_det.sv | 28 ++
 rtl/ping_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_ping_tx_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/opb_emu_pkg.sv
// Shared definitions for the ping/OPB transmit arbiter: state encoding,
// ping frame constants and the frame byte table.
package opb_emu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GAP = 2'd1,
    ST_PING     = 2'd2,
    ST_OPB      = 2'd3
  } arb_state_e;

  localparam logic [7:0] PING_HEADER  = 8'h5A;
  localparam logic [7:0] PING_TRAILER = 8'hA5;

  // Byte at position idx of a ping frame; without a sequence byte the trailer moves up to slot 9.
  function automatic logic [7:0] ping_byte(input logic [3:0] idx,
                                           input logic [7:0] seq,
                                           input logic       seq_en);
    logic [7:0] b;
    case (idx)
      4'd0:    b = PING_HEADER;
      4'd1:    b = 8'hAA;
      4'd2:    b = 8'hBB;
      4'd3:    b = 8'hCC;
      4'd4:    b = 8'hDD;
      4'd5:    b = 8'h11;
      4'd6:    b = 8'h22;
      4'd7:    b = 8'h33;
      4'd8:    b = 8'h44;
      4'd9:    b = seq_en ? seq : PING_TRAILER;
      4'd10:   b = PING_TRAILER;
      default: b = PING_TRAILER;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ping_tx_arbiter_if.sv
// Source-to-TX-FIFO byte path shared by msg_write, the arbiter and the TX FIFO.
interface ping_tx_arbiter_if;

  logic       SRC_TX_WR;
  logic [7:0] SRC_TX_DATA;
  logic       SRC_FRAME_BUSY;
  logic       SRC_TX_FULL;
  logic       TX_FIFO_WR;
  logic [7:0] TX_FIFO_DATA;
  logic       TX_FIFO_FULL;

  modport master (
    output SRC_TX_WR, SRC_TX_DATA, SRC_FRAME_BUSY, TX_FIFO_FULL,
    input  SRC_TX_FULL, TX_FIFO_WR, TX_FIFO_DATA
  );

  modport slave (
    input  SRC_TX_WR, SRC_TX_DATA, SRC_FRAME_BUSY, TX_FIFO_FULL,
    output SRC_TX_FULL, TX_FIFO_WR, TX_FIFO_DATA
  );

endinterface

// File: rtl/tick_edge_det.sv
// Brings the 2 kHz level into SYS_CLK and emits a one-cycle tick per rising edge.
module tick_edge_det (
  input  logic SYS_CLK,
  input  logic SYS_RST_N,
  input  logic PULSE_2KHZ,
  output logic tick
);

  logic [1:0] sync_r;
  logic       prev_r;
  logic       tick_r;

  // Two-flop synchroniser followed by registered rising-edge detection.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      sync_r <= 2'b00;
      prev_r <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], PULSE_2KHZ};
      prev_r <= sync_r[1];
      tick_r <= sync_r[1] & ~prev_r;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/ping_tx_arbiter.sv
// Interleaves periodic ping frames with msg_write traffic into the TX FIFO,
// suspending pings while the OPB bus is in use.
module ping_tx_arbiter
  import opb_emu_pkg::*;
#(
  parameter int PING_PERIOD_TICKS = 2000,
  parameter int RESUME_TICKS      = 10000,
  parameter int SEQ_EN            = 1
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST_N,
  input  logic                PULSE_2KHZ,
  input  logic                OPB_ACTIVITY,
  ping_tx_arbiter_if.slave    bus,
  output logic                PING_MODE,
  output logic [15:0]         PING_CNT,
  output logic                error_flag
);

  localparam logic [15:0] PERIOD_LAST = 16'(PING_PERIOD_TICKS - 1);
  localparam logic [15:0] RESUME_LAST = 16'(RESUME_TICKS - 1);
  localparam logic        RESUME_EN   = (RESUME_TICKS > 0);
  localparam logic        SEQ_ON      = (SEQ_EN != 0);
  localparam logic [3:0]  LAST_IDX    = SEQ_ON ? 4'd10 : 4'd9;

  arb_state_e  state_r, state_s;
  logic [15:0] tick_cnt_r, tick_cnt_s;
  logic [15:0] idle_cnt_r, idle_cnt_s;
  logic [3:0]  idx_r, idx_s;
  logic [15:0] ping_cnt_r, ping_cnt_s;
  logic        ping_mode_r, ping_mode_s;
  logic        err_r, err_s;
  logic        tick_s;
  logic        src_full_s;
  logic        fifo_wr_s;
  logic [7:0]  fifo_data_s;

  tick_edge_det u_tick (
    .SYS_CLK    (SYS_CLK),
    .SYS_RST_N  (SYS_RST_N),
    .PULSE_2KHZ (PULSE_2KHZ),
    .tick       (tick_s)
  );

  // State and counter registers; reset abandons any partial frame.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_r     <= ST_IDLE;
      tick_cnt_r  <= 16'd0;
      idle_cnt_r  <= 16'd0;
      idx_r       <= 4'd0;
      ping_cnt_r  <= 16'd0;
      ping_mode_r <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      tick_cnt_r  <= tick_cnt_s;
      idle_cnt_r  <= idle_cnt_s;
      idx_r       <= idx_s;
      ping_cnt_r  <= ping_cnt_s;
      ping_mode_r <= ping_mode_s;
      err_r       <= err_s;
    end
  end

  // Next-state logic; bus activity always drops ping mode but a running frame is finished first.
  always_comb begin
    state_s     = state_r;
    tick_cnt_s  = tick_cnt_r;
    idle_cnt_s  = 16'd0;
    idx_s       = idx_r;
    ping_cnt_s  = ping_cnt_r;
    ping_mode_s = OPB_ACTIVITY ? 1'b0 : ping_mode_r;
    case (state_r)
      ST_IDLE: begin
        if (OPB_ACTIVITY) begin
          state_s = ST_OPB;
        end else if (tick_s) begin
          if (tick_cnt_r == PERIOD_LAST) begin
            tick_cnt_s = 16'd0;
            state_s    = ST_WAIT_GAP;
          end else begin
            tick_cnt_s = tick_cnt_r + 16'd1;
          end
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
      ST_WAIT_GAP: begin
        if (OPB_ACTIVITY) begin
          state_s = ST_OPB;
        end else if (!bus.SRC_FRAME_BUSY && !bus.SRC_TX_WR) begin
          idx_s   = 4'd0;
          state_s = ST_PING;
        end else begin
          state_s = ST_WAIT_GAP;
        end
      end
      ST_PING: begin
        if (!bus.TX_FIFO_FULL) begin
          if (idx_r == LAST_IDX) begin
            idx_s      = 4'd0;
            ping_cnt_s = ping_cnt_r + 16'd1;
            state_s    = ping_mode_s ? ST_IDLE : ST_OPB;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      ST_OPB: begin
        if (OPB_ACTIVITY) begin
          idle_cnt_s = 16'd0;
        end else if (tick_s) begin
          if (RESUME_EN && (idle_cnt_r == RESUME_LAST)) begin
            ping_mode_s = 1'b1;
            tick_cnt_s  = 16'd0;
            state_s     = ST_IDLE;
          end else begin
            idle_cnt_s = idle_cnt_r + 16'd1;
          end
        end else begin
          idle_cnt_s = idle_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Byte path mux: ping bytes own the FIFO during a frame, otherwise source bytes pass straight through.
  always_comb begin
    src_full_s  = bus.TX_FIFO_FULL;
    fifo_wr_s   = 1'b0;
    fifo_data_s = bus.SRC_TX_DATA;
    if (state_r == ST_PING) begin
      src_full_s  = 1'b1;
      fifo_wr_s   = !bus.TX_FIFO_FULL;
      fifo_data_s = ping_byte(idx_r, ping_cnt_r[7:0], SEQ_ON);
    end else begin
      src_full_s  = bus.TX_FIFO_FULL;
      fifo_wr_s   = bus.SRC_TX_WR && !bus.TX_FIFO_FULL;
      fifo_data_s = bus.SRC_TX_DATA;
    end
    err_s = err_r | (bus.SRC_TX_WR & src_full_s);
  end

  assign bus.SRC_TX_FULL  = src_full_s;
  assign bus.TX_FIFO_WR   = fifo_wr_s;
  assign bus.TX_FIFO_DATA = fifo_data_s;
  assign PING_MODE        = ping_mode_r;
  assign PING_CNT         = ping_cnt_r;
  assign error_flag       = err_r;

endmodule

// File: tb/tb_ping_tx_arbiter.sv
// Directed bench for ping_tx_arbiter with a short ping period and resume time.
module tb_ping_tx_arbiter;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST_N;
  logic        PULSE_2KHZ;
  logic        OPB_ACTIVITY;
  logic        PING_MODE;
  logic [15:0] PING_CNT;
  logic        error_flag;

  ping_tx_arbiter_if bus ();

  ping_tx_arbiter #(
    .PING_PERIOD_TICKS (4),
    .RESUME_TICKS      (8),
    .SEQ_EN            (1)
  ) dut (
    .SYS_CLK      (SYS_CLK),
    .SYS_RST_N    (SYS_RST_N),
    .PULSE_2KHZ   (PULSE_2KHZ),
    .OPB_ACTIVITY (OPB_ACTIVITY),
    .bus          (bus),
    .PING_MODE    (PING_MODE),
    .PING_CNT     (PING_CNT),
    .error_flag   (error_flag)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       full;
    logic       exp_wr;
    logic [7:0] exp_data;
    logic       exp_src_full;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;
  int         overlap  = 0;
  logic [7:0] wq[$];
  int         wc[$];
  logic [7:0] body [9] = '{8'h5A, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

  // Record every byte the FIFO accepts, stamped with its cycle number.
  always @(negedge SYS_CLK) begin
    cycle++;
    if (bus.TX_FIFO_WR === 1'b1) begin
      wq.push_back(bus.TX_FIFO_DATA);
      wc.push_back(cycle);
      if (bus.TX_FIFO_FULL === 1'b1) overlap++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
      n_fail++;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge SYS_CLK); #1 PULSE_2KHZ = 1'b1;
      repeat (3) @(posedge SYS_CLK);
      #1 PULSE_2KHZ = 1'b0;
      repeat (2) @(posedge SYS_CLK);
    end
  endtask

  task automatic wait_writes(input int target, input string name);
    int n = 0;
    while (wq.size() < target && n < 200) begin
      @(negedge SYS_CLK); #1;
      n++;
    end
    if (wq.size() < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout with %0d writes, needed %0d", name, wq.size(), target);
    end
  endtask

  task automatic check_frame(input int base, input logic [7:0] seq, input int span, input string tag);
    logic [7:0] exp;
    logic [7:0] act;
    int         t0;
    int         t1;
    for (int i = 0; i < 11; i++) begin
      exp = (i < 9) ? body[i] : ((i == 9) ? seq : 8'hA5);
      act = (base + i < wq.size()) ? wq[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, act}, {24'd0, exp});
    end
    t0 = (base < wc.size()) ? wc[base] : 0;
    t1 = (base + 10 < wc.size()) ? wc[base + 10] : 0;
    check($sformatf("%s_span", tag), t1 - t0, span);
  endtask

  initial begin
    vec_t vecs [5];
    int   base;
    int   cyc_drop;

    vecs[0] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[1] = '{1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0};
    vecs[2] = '{1'b0, 8'h81, 1'b1, 1'b0, 8'h81, 1'b1};
    vecs[3] = '{1'b1, 8'hF0, 1'b0, 1'b1, 8'hF0, 1'b0};
    vecs[4] = '{1'b1, 8'h99, 1'b1, 1'b0, 8'h99, 1'b1};

    SYS_RST_N = 1'b0; PULSE_2KHZ = 1'b0; OPB_ACTIVITY = 1'b0;
    bus.SRC_TX_WR = 1'b0; bus.SRC_TX_DATA = 8'h00;
    bus.SRC_FRAME_BUSY = 1'b0; bus.TX_FIFO_FULL = 1'b0;
    repeat (3) @(posedge SYS_CLK);
    #1 SYS_RST_N = 1'b1;
    @(negedge SYS_CLK);
    check("rst_ping_mode", PING_MODE, 1);
    check("rst_ping_cnt", PING_CNT, 0);
    check("rst_error", error_flag, 0);
    check("rst_fifo_wr", bus.TX_FIFO_WR, 0);
    check("rst_src_full", bus.SRC_TX_FULL, 0);

    // Passthrough table while idling in ping mode; last vector writes into a full FIFO.
    for (int i = 0; i < 5; i++) begin
      @(posedge SYS_CLK); #1;
      bus.SRC_TX_WR = vecs[i].wr; bus.SRC_TX_DATA = vecs[i].data; bus.TX_FIFO_FULL = vecs[i].full;
      @(negedge SYS_CLK);
      check($sformatf("vec%0d_fifo_wr", i), bus.TX_FIFO_WR, vecs[i].exp_wr);
      check($sformatf("vec%0d_fifo_data", i), bus.TX_FIFO_DATA, vecs[i].exp_data);
      check($sformatf("vec%0d_src_full", i), bus.SRC_TX_FULL, vecs[i].exp_src_full);
    end
    @(posedge SYS_CLK); #1 bus.SRC_TX_WR = 1'b0; bus.TX_FIFO_FULL = 1'b0;
    @(negedge SYS_CLK);
    check("drop_sets_error", error_flag, 1);
    check("table_write_count", wq.size(), 2);
    @(posedge SYS_CLK); #1 SYS_RST_N = 1'b0;
    #1 check("reset_clears_error", error_flag, 0);
    repeat (2) @(posedge SYS_CLK);
    #1 SYS_RST_N = 1'b1;

    // First ping after the period; 11 consecutive bytes with sequence 00.
    base = wq.size();
    tick_n(4);
    wait_writes(base + 11, "ping1_wait");
    check_frame(base, 8'h00, 10, "ping1");
    @(negedge SYS_CLK);
    check("ping1_cnt", PING_CNT, 1);
    check("ping1_mode", PING_MODE, 1);

    // FIFO full for three cycles after byte 4.
    base = wq.size();
    tick_n(4);
    wait_writes(base + 5, "stall_wait");
    @(posedge SYS_CLK); #1 bus.TX_FIFO_FULL = 1'b1;
    repeat (3) @(posedge SYS_CLK);
    #1 bus.TX_FIFO_FULL = 1'b0;
    wait_writes(base + 11, "ping2_wait");
    check_frame(base, 8'h01, 13, "ping2");
    check("ping2_stall_gap", ((base + 5 < wc.size()) ? wc[base + 5] : 0) - wc[base + 4], 4);

    // Period expires while msg_write is mid-frame.
    base = wq.size();
    bus.SRC_FRAME_BUSY = 1'b1;
    tick_n(4);
    @(posedge SYS_CLK); #1 bus.SRC_TX_WR = 1'b1; bus.SRC_TX_DATA = 8'h77;
    @(posedge SYS_CLK); #1 bus.SRC_TX_WR = 1'b0;
    repeat (4) @(posedge SYS_CLK);
    #1;
    check("gap_holds_ping", wq.size(), base + 1);
    bus.SRC_FRAME_BUSY = 1'b0;
    cyc_drop = cycle;
    wait_writes(base + 12, "ping3_wait");
    check("gap_src_byte", (base < wq.size()) ? wq[base] : 8'hxx, 8'h77);
    check_frame(base + 1, 8'h02, 10, "ping3");
    check("ping3_start", (base + 1 < wc.size()) ? wc[base + 1] : 0, cyc_drop + 2);

    // Bus activity during a ping, then resume after 8 idle ticks.
    base = wq.size();
    tick_n(4);
    wait_writes(base + 4, "ping4_wait_b3");
    @(posedge SYS_CLK); #1 OPB_ACTIVITY = 1'b1;
    @(posedge SYS_CLK); #1 OPB_ACTIVITY = 1'b0;
    @(negedge SYS_CLK);
    check("act_clears_mode", PING_MODE, 0);
    wait_writes(base + 11, "ping4_wait");
    check_frame(base, 8'h03, 10, "ping4");
    @(posedge SYS_CLK); #1 bus.SRC_TX_WR = 1'b1; bus.SRC_TX_DATA = 8'hC3;
    @(negedge SYS_CLK);
    check("opb_cnt", PING_CNT, 4);
    check("opb_pass_wr", bus.TX_FIFO_WR, 1);
    check("opb_pass_data", bus.TX_FIFO_DATA, 8'hC3);
    check("opb_src_full", bus.SRC_TX_FULL, 0);
    @(posedge SYS_CLK); #1 bus.SRC_TX_WR = 1'b0;
    tick_n(7);
    @(posedge SYS_CLK); #1 OPB_ACTIVITY = 1'b1;
    @(posedge SYS_CLK); #1 OPB_ACTIVITY = 1'b0;
    tick_n(7);
    @(negedge SYS_CLK);
    check("idle_restarted", PING_MODE, 0);
    tick_n(1);
    @(negedge SYS_CLK);
    check("resume_mode", PING_MODE, 1);
    tick_n(3);
    repeat (10) @(posedge SYS_CLK);
    #1 check("no_early_ping", wq.size(), base + 12);

    // Source write during a ping is dropped and flagged.
    base = wq.size();
    tick_n(1);
    wait_writes(base + 3, "ping5_wait_b3");
    @(posedge SYS_CLK); #1 bus.SRC_TX_WR = 1'b1; bus.SRC_TX_DATA = 8'hEE;
    @(posedge SYS_CLK); #1 bus.SRC_TX_WR = 1'b0;
    wait_writes(base + 11, "ping5_wait");
    check_frame(base, 8'h04, 10, "ping5");
    repeat (20) @(posedge SYS_CLK);
    #1 check("error_sticky", error_flag, 1);
    check("ping5_no_extra", wq.size(), base + 11);

    // Reset at byte 6 abandons the frame.
    base = wq.size();
    tick_n(4);
    wait_writes(base + 6, "ping6_wait_b6");
    @(posedge SYS_CLK); #1 SYS_RST_N = 1'b0;
    #1;
    check("mid_rst_fifo_wr", bus.TX_FIFO_WR, 0);
    check("mid_rst_mode", PING_MODE, 1);
    check("mid_rst_cnt", PING_CNT, 0);
    check("mid_rst_error", error_flag, 0);
    check("mid_rst_src_full", bus.SRC_TX_FULL, 0);
    repeat (3) @(posedge SYS_CLK);
    #1 SYS_RST_N = 1'b1;
    repeat (30) @(posedge SYS_CLK);
    #1 check("abandoned_frame", wq.size(), base + 6);
    tick_n(3);
    repeat (10) @(posedge SYS_CLK);
    #1 check("post_rst_no_early", wq.size(), base + 6);
    tick_n(1);
    wait_writes(base + 17, "ping7_wait");
    check_frame(base + 6, 8'h00, 10, "ping7");
    @(negedge SYS_CLK);
    check("ping7_cnt", PING_CNT, 1);
    check("never_wr_when_full", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
